// File: rtl/xilinx_reset_sequencer.sv
// Brings up NUM_CH clocking primitives (IDELAYCTRL/MMCM/PLL) one at a time: pulse reset,
// wait for ready, retry on timeout, restart from the lowest channel that loses lock.
module xilinx_reset_sequencer #(
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned PULSE_CYCLES = 12,
  parameter int unsigned LOCK_TIMEOUT = 1024,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned SYNC_STAGES  = 2,
  localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              soft_rst,
  input  logic [NUM_CH-1:0] ch_ready,
  output logic [NUM_CH-1:0] ch_rst,
  output logic [NUM_CH-1:0] ch_fault,
  output logic              all_ready,
  output logic [CH_W-1:0]   cur_ch
);

  localparam int unsigned PulseW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam int unsigned TmoW   = $clog2(LOCK_TIMEOUT);
  localparam int unsigned RetryW = $clog2(MAX_RETRY + 1);

  localparam logic [PulseW-1:0] PulseLast = PulseW'(PULSE_CYCLES - 1);
  localparam logic [TmoW-1:0]   TmoLast   = TmoW'(LOCK_TIMEOUT - 1);
  localparam logic [RetryW-1:0] RetryMax  = RetryW'(MAX_RETRY);
  localparam logic [CH_W-1:0]   LastCh    = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {StPulse, StWait, StRun, StFault} state_t;

  state_t                               r_state;
  logic [CH_W-1:0]                      r_idx;
  logic [PulseW-1:0]                    r_pulse_cnt;
  logic [TmoW-1:0]                      r_tmo_cnt;
  logic [RetryW-1:0]                    r_retry;
  logic [NUM_CH-1:0]                    r_ch_rst;
  logic [NUM_CH-1:0]                    r_ch_fault;
  logic                                 r_all_ready;
  logic [SYNC_STAGES-1:0][NUM_CH-1:0]   r_sync;

  logic [NUM_CH-1:0] w_rdy_s;
  logic [NUM_CH-1:0] w_below_idx;
  logic [NUM_CH-1:0] w_from_idx;
  logic [NUM_CH-1:0] w_above_idx;
  logic [NUM_CH-1:0] w_lost;
  logic [NUM_CH-1:0] w_from_lost;
  logic [CH_W-1:0]   w_lost_idx;
  logic              w_found;
  logic              w_lock_loss;
  logic [RetryW-1:0] w_retry_inc;

  assign w_rdy_s     = r_sync[SYNC_STAGES-1];
  assign w_retry_inc = r_retry + RetryW'(1);

  // Channel masks relative to the current index and to the lowest channel that lost lock.
  always_comb begin
    w_below_idx = '0;
    w_from_idx  = '0;
    w_above_idx = '0;
    w_from_lost = '0;
    w_lost_idx  = '0;
    w_found     = 1'b0;
    for (int unsigned j = 0; j < NUM_CH; j++) begin
      w_below_idx[j] = (CH_W'(j) <  r_idx);
      w_from_idx[j]  = (CH_W'(j) >= r_idx);
      w_above_idx[j] = (CH_W'(j) >  r_idx);
    end
    w_lost      = ~w_rdy_s & ((r_state == StRun) ? {NUM_CH{1'b1}} : w_below_idx);
    w_lock_loss = |w_lost;
    for (int unsigned j = 0; j < NUM_CH; j++) begin
      if (w_lost[j] && !w_found) begin
        w_lost_idx = CH_W'(j);
        w_found    = 1'b1;
      end
    end
    for (int unsigned j = 0; j < NUM_CH; j++) begin
      w_from_lost[j] = (CH_W'(j) >= w_lost_idx);
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_sync      <= '0;
      r_state     <= StPulse;
      r_idx       <= '0;
      r_pulse_cnt <= '0;
      r_tmo_cnt   <= '0;
      r_retry     <= '0;
      r_ch_rst    <= '1;
      r_ch_fault  <= '0;
      r_all_ready <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], ch_ready};
      if (soft_rst) begin
        r_state     <= StPulse;
        r_idx       <= '0;
        r_pulse_cnt <= '0;
        r_tmo_cnt   <= '0;
        r_retry     <= '0;
        r_ch_rst    <= '1;
        r_ch_fault  <= '0;
        r_all_ready <= 1'b0;
      end else if (r_state != StFault && w_lock_loss) begin
        // Lock loss outranks a coincident ready or timeout on the current channel.
        r_state     <= StPulse;
        r_idx       <= w_lost_idx;
        r_pulse_cnt <= '0;
        r_tmo_cnt   <= '0;
        r_retry     <= '0;
        r_ch_rst    <= w_from_lost;
        r_all_ready <= 1'b0;
      end else begin
        unique case (r_state)
          StPulse: begin
            if (r_pulse_cnt == PulseLast) begin
              r_state   <= StWait;
              r_tmo_cnt <= '0;
              r_ch_rst  <= w_above_idx;
            end else begin
              r_pulse_cnt <= r_pulse_cnt + PulseW'(1);
            end
          end
          StWait: begin
            if (w_rdy_s[r_idx]) begin
              if (r_idx == LastCh) begin
                r_state     <= StRun;
                r_all_ready <= 1'b1;
                r_ch_rst    <= '0;
              end else begin
                r_state     <= StPulse;
                r_idx       <= r_idx + CH_W'(1);
                r_pulse_cnt <= '0;
                r_retry     <= '0;
              end
            end else if (r_tmo_cnt == TmoLast) begin
              r_retry  <= w_retry_inc;
              r_ch_rst <= w_from_idx;
              if (w_retry_inc == RetryMax) begin
                r_state           <= StFault;
                r_ch_fault[r_idx] <= 1'b1;
              end else begin
                r_state     <= StPulse;
                r_pulse_cnt <= '0;
              end
            end else begin
              r_tmo_cnt <= r_tmo_cnt + TmoW'(1);
            end
          end
          StRun: begin
            r_all_ready <= 1'b1;
          end
          StFault: begin
            r_all_ready <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ch_rst    = r_ch_rst;
  assign ch_fault  = r_ch_fault;
  assign all_ready = r_all_ready;
  assign cur_ch    = r_idx;

endmodule

// File: tb/tb_xilinx_reset_sequencer.sv
// Scoreboard bench: each scenario queues expected outputs per cycle, then drives it and compares.
module tb_xilinx_reset_sequencer;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       soft_rst = 1'b0;
  logic [1:0] ch_ready = 2'b00;
  logic [1:0] ch_rst;
  logic [1:0] ch_fault;
  logic       all_ready;
  logic [0:0] cur_ch;

  always #5 clock = ~clock;

  xilinx_reset_sequencer #(
    .NUM_CH      (2),
    .PULSE_CYCLES(4),
    .LOCK_TIMEOUT(16),
    .MAX_RETRY   (2),
    .SYNC_STAGES (2)
  ) dut (
    .clock    (clock),
    .rst_n    (rst_n),
    .soft_rst (soft_rst),
    .ch_ready (ch_ready),
    .ch_rst   (ch_rst),
    .ch_fault (ch_fault),
    .all_ready(all_ready),
    .cur_ch   (cur_ch)
  );

  typedef struct {
    int         cyc;
    logic [1:0] rst;
    logic [1:0] flt;
    logic       all;
    logic       cur;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic void expect_at(int c, logic [1:0] r, logic [1:0] f, logic a, logic u);
    sb.push_back('{c, r, f, a, u});
  endfunction

  // Cycle t is the t-th rising edge of the scenario; inputs for t are set before that edge.
  task automatic test_reset();
    exp_t e;
    sb.delete();
    expect_at(1, 2'b11, 2'b00, 1'b0, 1'b0);
    expect_at(3, 2'b11, 2'b00, 1'b0, 1'b0);
    for (int t = 1; t <= 3; t++) begin
      rst_n = 1'b0; soft_rst = 1'b1; ch_ready = 2'b11;
      @(posedge clock); #1;
      while (sb.size() != 0 && sb[0].cyc == t) begin
        e = sb.pop_front(); n_vec++;
        if ({ch_rst, ch_fault, all_ready, cur_ch} !== {e.rst, e.flt, e.all, e.cur}) begin
          n_err++;
          $display("FAIL reset cyc=%0d got rst=%b flt=%b all=%b cur=%0d want rst=%b flt=%b all=%b cur=%0d",
                   t, ch_rst, ch_fault, all_ready, cur_ch, e.rst, e.flt, e.all, e.cur);
        end
      end
    end
    soft_rst = 1'b0;
    if (sb.size() != 0) begin n_err++; $display("FAIL reset: %0d checks unreached", sb.size()); end
  endtask

  task automatic test_bringup();
    exp_t e;
    sb.delete();
    expect_at(1,  2'b11, 2'b00, 1'b0, 1'b0);
    expect_at(4,  2'b11, 2'b00, 1'b0, 1'b0);
    expect_at(5,  2'b10, 2'b00, 1'b0, 1'b0);
    expect_at(7,  2'b10, 2'b00, 1'b0, 1'b0);
    expect_at(8,  2'b10, 2'b00, 1'b0, 1'b1);
    expect_at(11, 2'b10, 2'b00, 1'b0, 1'b1);
    expect_at(12, 2'b00, 2'b00, 1'b0, 1'b1);
    expect_at(16, 2'b00, 2'b00, 1'b0, 1'b1);
    expect_at(17, 2'b00, 2'b00, 1'b1, 1'b1);
    expect_at(20, 2'b00, 2'b00, 1'b1, 1'b1);
    for (int t = 1; t <= 20; t++) begin
      rst_n = (t >= 2);
      if (t == 1)  ch_ready = 2'b00;
      if (t == 6)  ch_ready[0] = 1'b1;
      if (t == 15) ch_ready[1] = 1'b1;
      @(posedge clock); #1;
      while (sb.size() != 0 && sb[0].cyc == t) begin
        e = sb.pop_front(); n_vec++;
        if ({ch_rst, ch_fault, all_ready, cur_ch} !== {e.rst, e.flt, e.all, e.cur}) begin
          n_err++;
          $display("FAIL bringup cyc=%0d got rst=%b flt=%b all=%b cur=%0d want rst=%b flt=%b all=%b cur=%0d",
                   t, ch_rst, ch_fault, all_ready, cur_ch, e.rst, e.flt, e.all, e.cur);
        end
      end
    end
    if (sb.size() != 0) begin n_err++; $display("FAIL bringup: %0d checks unreached", sb.size()); end
  endtask

  task automatic test_lock_loss();
    exp_t e;
    sb.delete();
    expect_at(11, 2'b00, 2'b00, 1'b1, 1'b1);
    expect_at(15, 2'b00, 2'b00, 1'b1, 1'b1);
    expect_at(16, 2'b11, 2'b00, 1'b0, 1'b0);
    expect_at(20, 2'b10, 2'b00, 1'b0, 1'b0);
    expect_at(21, 2'b10, 2'b00, 1'b0, 1'b1);
    expect_at(25, 2'b00, 2'b00, 1'b0, 1'b1);
    expect_at(26, 2'b00, 2'b00, 1'b1, 1'b1);
    for (int t = 1; t <= 26; t++) begin
      rst_n = (t >= 2);
      if (t == 1)  ch_ready = 2'b11;
      if (t == 14) ch_ready[0] = 1'b0;
      if (t == 17) ch_ready[0] = 1'b1;
      @(posedge clock); #1;
      while (sb.size() != 0 && sb[0].cyc == t) begin
        e = sb.pop_front(); n_vec++;
        if ({ch_rst, ch_fault, all_ready, cur_ch} !== {e.rst, e.flt, e.all, e.cur}) begin
          n_err++;
          $display("FAIL lock_loss cyc=%0d got rst=%b flt=%b all=%b cur=%0d want rst=%b flt=%b all=%b cur=%0d",
                   t, ch_rst, ch_fault, all_ready, cur_ch, e.rst, e.flt, e.all, e.cur);
        end
      end
    end
    if (sb.size() != 0) begin n_err++; $display("FAIL lock_loss: %0d checks unreached", sb.size()); end
  endtask

  // Starts in RUN, left there by test_lock_loss.
  task automatic test_partial_loss();
    exp_t e;
    sb.delete();
    expect_at(1, 2'b00, 2'b00, 1'b1, 1'b1);
    expect_at(4, 2'b00, 2'b00, 1'b1, 1'b1);
    expect_at(5, 2'b10, 2'b00, 1'b0, 1'b1);
    expect_at(8, 2'b10, 2'b00, 1'b0, 1'b1);
    expect_at(9, 2'b00, 2'b00, 1'b0, 1'b1);
    for (int t = 1; t <= 9; t++) begin
      if (t == 3) ch_ready[1] = 1'b0;
      @(posedge clock); #1;
      while (sb.size() != 0 && sb[0].cyc == t) begin
        e = sb.pop_front(); n_vec++;
        if ({ch_rst, ch_fault, all_ready, cur_ch} !== {e.rst, e.flt, e.all, e.cur}) begin
          n_err++;
          $display("FAIL partial_loss cyc=%0d got rst=%b flt=%b all=%b cur=%0d want rst=%b flt=%b all=%b cur=%0d",
                   t, ch_rst, ch_fault, all_ready, cur_ch, e.rst, e.flt, e.all, e.cur);
        end
      end
    end
    if (sb.size() != 0) begin n_err++; $display("FAIL partial_loss: %0d checks unreached", sb.size()); end
  endtask

  task automatic test_timeout_fault();
    exp_t e;
    sb.delete();
    expect_at(5,  2'b10, 2'b00, 1'b0, 1'b0);
    expect_at(20, 2'b10, 2'b00, 1'b0, 1'b0);
    expect_at(21, 2'b11, 2'b00, 1'b0, 1'b0);
    expect_at(24, 2'b11, 2'b00, 1'b0, 1'b0);
    expect_at(25, 2'b10, 2'b00, 1'b0, 1'b0);
    expect_at(40, 2'b10, 2'b00, 1'b0, 1'b0);
    expect_at(41, 2'b11, 2'b01, 1'b0, 1'b0);
    expect_at(50, 2'b11, 2'b01, 1'b0, 1'b0);
    for (int t = 1; t <= 50; t++) begin
      rst_n = (t >= 2);
      if (t == 1) ch_ready = 2'b00;
      @(posedge clock); #1;
      while (sb.size() != 0 && sb[0].cyc == t) begin
        e = sb.pop_front(); n_vec++;
        if ({ch_rst, ch_fault, all_ready, cur_ch} !== {e.rst, e.flt, e.all, e.cur}) begin
          n_err++;
          $display("FAIL timeout_fault cyc=%0d got rst=%b flt=%b all=%b cur=%0d want rst=%b flt=%b all=%b cur=%0d",
                   t, ch_rst, ch_fault, all_ready, cur_ch, e.rst, e.flt, e.all, e.cur);
        end
      end
    end
    if (sb.size() != 0) begin n_err++; $display("FAIL timeout_fault: %0d checks unreached", sb.size()); end
  endtask

  // Starts in FAULT on channel 0, left there by test_timeout_fault.
  task automatic test_soft_rst();
    exp_t e;
    sb.delete();
    expect_at(1, 2'b11, 2'b01, 1'b0, 1'b0);
    expect_at(2, 2'b11, 2'b00, 1'b0, 1'b0);
    expect_at(4, 2'b11, 2'b00, 1'b0, 1'b0);
    expect_at(7, 2'b11, 2'b00, 1'b0, 1'b0);
    expect_at(8, 2'b10, 2'b00, 1'b0, 1'b0);
    for (int t = 1; t <= 8; t++) begin
      soft_rst = (t >= 2 && t <= 4);
      @(posedge clock); #1;
      while (sb.size() != 0 && sb[0].cyc == t) begin
        e = sb.pop_front(); n_vec++;
        if ({ch_rst, ch_fault, all_ready, cur_ch} !== {e.rst, e.flt, e.all, e.cur}) begin
          n_err++;
          $display("FAIL soft_rst cyc=%0d got rst=%b flt=%b all=%b cur=%0d want rst=%b flt=%b all=%b cur=%0d",
                   t, ch_rst, ch_fault, all_ready, cur_ch, e.rst, e.flt, e.all, e.cur);
        end
      end
    end
    soft_rst = 1'b0;
    if (sb.size() != 0) begin n_err++; $display("FAIL soft_rst: %0d checks unreached", sb.size()); end
  endtask

  // Channel 1 faults; a later loss on channel 0 must be ignored until rst_n clears the fault.
  task automatic test_fault_hold_rst();
    exp_t e;
    sb.delete();
    expect_at(5,  2'b10, 2'b00, 1'b0, 1'b0);
    expect_at(6,  2'b10, 2'b00, 1'b0, 1'b1);
    expect_at(10, 2'b00, 2'b00, 1'b0, 1'b1);
    expect_at(25, 2'b00, 2'b00, 1'b0, 1'b1);
    expect_at(26, 2'b10, 2'b00, 1'b0, 1'b1);
    expect_at(30, 2'b00, 2'b00, 1'b0, 1'b1);
    expect_at(45, 2'b00, 2'b00, 1'b0, 1'b1);
    expect_at(46, 2'b10, 2'b10, 1'b0, 1'b1);
    expect_at(52, 2'b10, 2'b10, 1'b0, 1'b1);
    expect_at(54, 2'b11, 2'b00, 1'b0, 1'b0);
    for (int t = 1; t <= 54; t++) begin
      soft_rst = (t == 1);
      rst_n    = (t < 54);
      if (t == 1)  ch_ready = 2'b01;
      if (t == 48) ch_ready = 2'b00;
      @(posedge clock); #1;
      while (sb.size() != 0 && sb[0].cyc == t) begin
        e = sb.pop_front(); n_vec++;
        if ({ch_rst, ch_fault, all_ready, cur_ch} !== {e.rst, e.flt, e.all, e.cur}) begin
          n_err++;
          $display("FAIL fault_hold_rst cyc=%0d got rst=%b flt=%b all=%b cur=%0d want rst=%b flt=%b all=%b cur=%0d",
                   t, ch_rst, ch_fault, all_ready, cur_ch, e.rst, e.flt, e.all, e.cur);
        end
      end
    end
    soft_rst = 1'b0;
    if (sb.size() != 0) begin n_err++; $display("FAIL fault_hold_rst: %0d checks unreached", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_lock_loss();
    test_partial_loss();
    test_timeout_fault();
    test_soft_rst();
    test_fault_hold_rst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
